// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-index width, zero-register index.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package pipe_pkg;

    // Architectural register index width and the hard-wired zero register.
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

    // Hazard controller FSM encoding; ST_RSVD is never entered on purpose.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RSVD     = 2'd3
    } hz_state_e;

    // True when an ID source is actually read and names the EX destination.
    function automatic logic src_hit(
        input logic                 use_src,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dst
    );
        return use_src & (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_wait_timer.sv
// wait_timer: counts consecutive enabled cycles and flags the LIMIT-th one.
// Latency: expired is combinational in the LIMIT-th enabled cycle; count updates on clk rising edge.
// Backpressure: none; clear has priority over count and the count never runs past LIMIT-1.
module wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The cycle that would make LIMIT consecutive counted cycles is the expiry cycle.
    assign expired = count_en & (cnt_q == LAST);

    // Next count: clear wins, otherwise advance on every enabled non-expiring cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, zeroed asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and MEM-wait hold control (HAZARD_STATS_EN adds stall/flush counters).
// Latency: control outputs are combinational from state + hazard inputs; state/timeout_err update on clk rising edge.
// Backpressure: a pending data access (dmem_req & ~dmem_ready) freezes fetch/decode until ready or TIMEOUT_CYC wait cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] id_Rn,
    input  logic [REG_IDX_W-1:0] id_Rm,
    input  logic                 id_useRn,
    input  logic                 id_useRm,
    input  logic                 ex_memRead,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_brTaken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_wr_en,
    output logic                 ifid_wr_en,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 pipe_hold,
    output logic [1:0]           state,
    output logic                 timeout_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    hz_state_e state_q, state_d;
    logic      br_q, br_d;        // branch seen on the cycle the MEM wait began
    logic      aband_q, aband_d;  // timed-out access still presented; ignore it until it drops
    logic      err_q, err_d;

    logic hold_raw;
    logic in_wait;
    logic in_flush;
    logic timer_en;
    logic expired;
    logic mem_hold;
    logic load_use;

    logic pc_wr_c, ifid_wr_c, bubble_c, ifid_flush_c, idex_flush_c, hold_c;

    assign hold_raw = dmem_req & ~dmem_ready & ~aband_q;
    assign in_wait  = (state_q == ST_MEM_WAIT);
    assign in_flush = (state_q == ST_FLUSH);
    assign timer_en = in_wait & hold_raw;
    assign mem_hold = hold_raw & ~expired;
    assign load_use = ex_memRead & (ex_rd != XZR_IDX) &
                      (src_hit(id_useRn, id_Rn, ex_rd) | src_hit(id_useRm, id_Rm, ex_rd));

    wait_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (timer_en),
        .clear    (~timer_en | expired),
        .expired  (expired)
    );

    // Event priority: memory hold, then branch flush, then FLUSH tail, then load-use stall.
    always_comb begin
        pc_wr_c      = 1'b1;
        ifid_wr_c    = 1'b1;
        bubble_c     = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        hold_c       = 1'b0;
        state_d      = ST_RUN;
        br_d         = br_q;
        aband_d      = aband_q & dmem_req & ~dmem_ready;
        err_d        = err_q;

        if (mem_hold) begin
            pc_wr_c   = 1'b0;
            ifid_wr_c = 1'b0;
            hold_c    = 1'b1;
            state_d   = ST_MEM_WAIT;
            if (!in_wait) begin
                br_d = ex_brTaken;
            end
        end else begin
            if (ex_brTaken) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                state_d      = ST_FLUSH;
            end else if (in_flush) begin
                ifid_flush_c = 1'b1;
            end else if (load_use) begin
                pc_wr_c   = 1'b0;
                ifid_wr_c = 1'b0;
                bubble_c  = 1'b1;
            end

            if (in_wait) begin
                if (br_q) begin
                    state_d = ST_FLUSH;
                end
                br_d = 1'b0;
            end

            if (expired) begin
                state_d = ST_RUN;
                err_d   = 1'b1;
                aband_d = 1'b1;
                br_d    = 1'b0;
            end
        end
    end

    // FSM and sticky status registers; the unused encoding falls back to RUN via state_d.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            br_q    <= 1'b0;
            aband_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            aband_q <= aband_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced quiet while reset is asserted so nothing advances.
    assign pc_wr_en    = pc_wr_c      & reset_n;
    assign ifid_wr_en  = ifid_wr_c    & reset_n;
    assign idex_bubble = bubble_c     & reset_n;
    assign ifid_flush  = ifid_flush_c & reset_n;
    assign idex_flush  = idex_flush_c & reset_n;
    assign pipe_hold   = hold_c       & reset_n;
    assign state       = state_q;
    assign timeout_err = err_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counts of load-use bubble cycles and accepted branch flushes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bubble_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (idex_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed corner cases plus randomized traffic against a behavioural model.
// Latency: outputs compared mid-cycle (after the falling edge), model advanced on each rising edge.
// Backpressure: dmem_ready is randomized while dmem_req is held, including waits long enough to time out.
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;
    localparam int CW = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_Rn, id_Rm, ex_rd;
    logic       id_useRn, id_useRm, ex_memRead, ex_brTaken, dmem_req, dmem_ready;
    logic       pc_wr_en, ifid_wr_en, idex_bubble, ifid_flush, idex_flush, pipe_hold, timeout_err;
    logic [1:0] state;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_Rn       (id_Rn),
        .id_Rm       (id_Rm),
        .id_useRn    (id_useRn),
        .id_useRm    (id_useRm),
        .ex_memRead  (ex_memRead),
        .ex_rd       (ex_rd),
        .ex_brTaken  (ex_brTaken),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_wr_en    (pc_wr_en),
        .ifid_wr_en  (ifid_wr_en),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .pipe_hold   (pipe_hold),
        .state       (state),
        .timeout_err (timeout_err)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Behavioural model state: which phase the pipeline is in, how long it has waited, etc.
    int m_state;   // 0 run, 1 flush tail, 2 waiting on memory
    int m_waits;   // wait-state cycles already spent on the current access
    bit m_br, m_aband, m_err;
    int m_stall, m_flush;

    bit e_pc, e_ifid, e_bub, e_iff, e_idf, e_hold;
    int nx_state, nx_waits;
    bit nx_br, nx_aband, nx_err;

    task automatic model_reset();
        m_state = 0; m_waits = 0; m_br = 0; m_aband = 0; m_err = 0;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit waiting, expire, hold, lu;
        waiting = dmem_req && !dmem_ready && !m_aband;
        expire  = waiting && (m_state == 2) && (m_waits + 1 == TO);
        hold    = waiting && !expire;
        lu      = ex_memRead && (ex_rd != 5'd31) &&
                  ((id_useRn && id_Rn == ex_rd) || (id_useRm && id_Rm == ex_rd));
        e_pc = 1; e_ifid = 1; e_bub = 0; e_iff = 0; e_idf = 0; e_hold = 0;
        nx_state = 0; nx_waits = 0; nx_br = m_br; nx_err = m_err;
        nx_aband = m_aband && dmem_req && !dmem_ready;
        if (hold) begin
            e_pc = 0; e_ifid = 0; e_hold = 1; nx_state = 2;
            if (m_state == 2) nx_waits = m_waits + 1;
            else              nx_br = ex_brTaken;
        end else begin
            if (ex_brTaken) begin
                e_iff = 1; e_idf = 1; nx_state = 1;
            end else if (m_state == 1) begin
                e_iff = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
            end
            if (m_state == 2) begin
                if (m_br) nx_state = 1;
                nx_br = 0;
            end
            if (expire) begin
                nx_state = 0; nx_err = 1; nx_aband = 1; nx_br = 0;
            end
        end
    endtask

    // One clock cycle: inputs already set after a falling edge; compare, then advance.
    task automatic run_cycle();
        #1;
        model_eval();
        chk("outs", {state, pc_wr_en, ifid_wr_en, idex_bubble, ifid_flush, idex_flush, pipe_hold, timeout_err},
            {m_state[1:0], e_pc, e_ifid, e_bub, e_iff, e_idf, e_hold, m_err});
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
        @(posedge clk);
        if (e_bub && m_stall < 65535) m_stall++;
        if (e_idf && m_flush < 65535) m_flush++;
        m_state = nx_state; m_waits = nx_waits; m_br = nx_br; m_aband = nx_aband; m_err = nx_err;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_Rn = 0; id_Rm = 0; id_useRn = 0; id_useRm = 0; ex_memRead = 0; ex_rd = 0;
        ex_brTaken = 0; dmem_req = 0; dmem_ready = 1;
    endtask

    // Reset applied at a falling edge, checked while asserted, released on the next falling edge.
    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        #1;
        chk("rst_pc", pc_wr_en, 0);
        chk("rst_ifid", ifid_wr_en, 0);
        chk("rst_state", state, 0);
        chk("rst_err", timeout_err, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        case ($urandom_range(0, 3))
            0:       r = 5'd5;
            1:       r = 5'd31;
            default: r = 5'($urandom_range(0, 31));
        endcase
        return r;
    endfunction

    initial begin
        reset_n = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use on Rn: one stall cycle, then normal.
        ex_memRead = 1; ex_rd = 5; id_Rn = 5; id_useRn = 1;
        #1;
        chk("lu_pc", pc_wr_en, 0);
        chk("lu_bubble", idex_bubble, 1);
        run_cycle();
        idle_inputs();
        #1;
        chk("lu_after_pc", pc_wr_en, 1);
        chk("lu_after_bubble", idex_bubble, 0);
        run_cycle();

        // Load into the zero register never stalls.
        ex_memRead = 1; ex_rd = 31; id_Rn = 31; id_useRn = 1;
        #1;
        chk("xzr_pc", pc_wr_en, 1);
        chk("xzr_bubble", idex_bubble, 0);
        run_cycle();

        // Taken branch: both flushes, then IF/ID flush only, then RUN.
        idle_inputs(); ex_brTaken = 1;
        #1;
        chk("br_n_flush", {ifid_flush, idex_flush}, 2'b11);
        run_cycle();
        idle_inputs();
        #1;
        chk("br_n1_flush", {ifid_flush, idex_flush}, 2'b10);
        chk("br_n1_state", state, 1);
        run_cycle();
        chk("br_n2_state", state, 0);
        run_cycle();

        // Memory wait of 3 cycles with a coincident load-use: hold wins, no bubble.
        for (int i = 0; i < 3; i++) begin
            dmem_req = 1; dmem_ready = 0; ex_memRead = 1; ex_rd = 5; id_Rn = 5; id_useRn = 1;
            #1;
            chk("mw_hold", pipe_hold, 1);
            chk("mw_bubble", idex_bubble, 0);
            run_cycle();
        end
        idle_inputs(); dmem_req = 1; dmem_ready = 1;
        #1;
        chk("mw_release_hold", pipe_hold, 0);
        run_cycle();
        idle_inputs();
        chk("mw_run_after", state, 0);
        run_cycle();

        // Memory never ready: timeout after TO wait-state cycles, sticky until reset.
        for (int i = 0; i < 14; i++) begin
            idle_inputs(); dmem_req = 1; dmem_ready = 0;
            #1;
            chk("to_hold", pipe_hold, (i <= TO - 1) ? 1 : 0);
            chk("to_err", timeout_err, (i >= TO + 1) ? 1 : 0);
            run_cycle();
        end
        do_reset();
        chk("to_err_cleared", timeout_err, 0);

        // Reset asserted mid-wait takes effect without a clock edge.
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); dmem_req = 1; dmem_ready = 0;
            run_cycle();
        end
        chk("pre_rst_state", state, 2);
        chk("pre_rst_wait_cnt", 32'(dut.u_wait_timer.cnt_q), 32'(m_waits));
        #2;
        reset_n = 0;
        #1;
        chk("async_state", state, 0);
        chk("async_wait_cnt", 32'(dut.u_wait_timer.cnt_q), 0);
        chk("async_pc", pc_wr_en, 0);
        @(negedge clk);
        idle_inputs();
        reset_n = 1;
        model_reset();

        // Randomized traffic; a held access is kept presented until it completes.
        for (int c = 0; c < 1500; c++) begin
            logic keep;
            keep = dmem_req && !dmem_ready;
            ex_memRead = ($urandom_range(0, 2) == 0);
            ex_rd      = pick_reg();
            id_Rn      = pick_reg();
            id_Rm      = pick_reg();
            id_useRn   = 1'($urandom_range(0, 1));
            id_useRm   = 1'($urandom_range(0, 1));
            ex_brTaken = ($urandom_range(0, 7) == 0);
            dmem_req   = keep ? 1'b1 : ($urandom_range(0, 5) == 0);
            dmem_ready = ($urandom_range(0, 2) == 0);
            if (c == 750) do_reset();
            else          run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, memory-wait cycles before the timeout error is raised.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports id_Rn, id_Rm  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports id_useRn, id_useRm  input  1 each  high when that ID source is actually read.
REQ-007 SHALL have ports ex_memRead  input  1  and ex_rd  input  5  (load in EX and its destination).
REQ-008 SHALL have port ex_brTaken  input  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have ports dmem_req  input  1  and dmem_ready  input  1  (MEM-stage access and completion).
REQ-010 SHALL have outputs pc_wr_en, ifid_wr_en, idex_bubble, ifid_flush, idex_flush, pipe_hold  1 each.
REQ-011 SHALL have outputs state  output  2  current FSM state, and timeout_err  output  1  sticky error.

Function
REQ-012 SHALL implement FSM states RUN=0, FLUSH=1, MEM_WAIT=2; encoding 3 is unreachable and SHALL return to RUN.
REQ-013 SHALL detect load-use as ex_memRead & ex_rd!=31 & ((id_useRn & id_Rn==ex_rd) | (id_useRm & id_Rm==ex_rd)).
REQ-014 SHALL, in RUN on load-use, combinationally drive pc_wr_en=0, ifid_wr_en=0, idex_bubble=1 that cycle only; state stays RUN.
REQ-015 SHALL, in RUN or FLUSH on ex_brTaken, drive ifid_flush=1 and idex_flush=1 that cycle and enter FLUSH for exactly one following cycle.
REQ-016 SHALL, in FLUSH, drive ifid_flush=1 and suppress load-use stalling; return to RUN next cycle unless a new ex_brTaken arrives.
REQ-017 SHALL, in any state when dmem_req & ~dmem_ready, drive pipe_hold=1, pc_wr_en=0, ifid_wr_en=0, all flushes/bubble 0, and enter or remain in MEM_WAIT.
REQ-018 SHALL leave MEM_WAIT the cycle after dmem_ready=1; return to FLUSH if an ex_brTaken was latched on entry, else RUN.
REQ-019 SHALL apply priority MEM_WAIT hold > branch flush > load-use stall when events coincide.
REQ-020 SHALL count consecutive MEM_WAIT cycles; at TIMEOUT_CYC set timeout_err=1, force state to RUN, and release pipe_hold.
REQ-021 SHALL keep timeout_err set until reset; the wait counter clears on every MEM_WAIT exit.
REQ-022 SHALL drive pc_wr_en=1, ifid_wr_en=1, all others 0 in RUN with no event.

Reset
REQ-023 SHALL on reset_n low immediately force state=RUN, timeout_err=0, wait counter=0, latched branch=0, statistics=0.
REQ-024 SHALL hold pc_wr_en=0 and ifid_wr_en=0 while reset_n is low, and resume RUN outputs on the first edge after release.

Configuration
REQ-025 SHALL, with HAZARD_STATS_EN defined, add outputs stall_cnt and flush_cnt (CNT_W, saturating) counting load-use stall cycles and branch-flush events.
REQ-026 SHALL, without HAZARD_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-027 SHALL take the state enum, the XZR index 31 constant and the register-index width from shared package pipe_pkg.
REQ-028 SHALL place the timeout counter in sub-module wait_timer (count, clear, expired output).

Verification
REQ-029 SHALL cover: ex_memRead=1, ex_rd=5, id_Rn=5, id_useRn=1 -> one cycle pc_wr_en=0, idex_bubble=1, then normal.
REQ-030 SHALL cover: same with ex_rd=31 -> no stall.
REQ-031 SHALL cover: ex_brTaken pulse -> both flushes cycle N, ifid_flush only cycle N+1, state RUN at N+2.
REQ-032 SHALL cover: dmem_req=1, dmem_ready low 3 cycles with coincident load-use -> pipe_hold 3 cycles, no bubble, RUN after ready.
REQ-033 SHALL cover: dmem_ready never asserted, TIMEOUT_CYC=8 -> timeout_err=1 after 8 wait cycles, sticky until reset_n low.
REQ-034 SHALL cover: reset_n low mid-MEM_WAIT -> state=RUN and counters zero without waiting for a clock edge.
